noc_vchannel_mux_credit: RTL

- Credit-based, registered N:1 virtual-channel multiplexer for the router output port.
- Merges CHANNELS virtual-channel flit streams onto one physical link, one flit per cycle.
- Tracks downstream per-VC buffer space with credit counters instead of a combinational out_ready, so there is no ready path across the link.
- Selectable round-robin or fixed-priority arbitration; output is registered (1-cycle latency).

---
 rtl/noc_vchannel_mux_credit.sv | 190 +++++++++++++++++++
 1 files changed

// File: rtl/noc_vchannel_mux_credit.sv
// noc_vchannel_mux_credit
//
// Credit-based N:1 virtual-channel multiplexer for a router output port.
// CHANNELS flit streams are merged onto one physical link, one flit per cycle.
// Downstream buffer space is tracked locally with one credit counter per VC,
// so no ready signal has to cross the link. The flit, its last marker and a
// one-hot VC tag are registered, giving one cycle of latency.
//
// Ports:
//   clk            clock, rising edge
//   rst            synchronous active-high reset
//   in_flit        per-VC flit payload
//   in_last        per-VC last-flit-of-packet marker (carried through only)
//   in_valid       per-VC flit valid
//   in_ready       per-VC accept, one-hot or zero (the arbiter grant)
//   out_flit       registered link flit, holds while idle
//   out_last       registered last marker, holds while idle
//   out_valid      registered one-hot VC tag; zero means the link is idle
//   credit_return  per-VC pulse, one per freed downstream slot
//   credit_err     sticky flag: a credit came back for a VC already at CREDITS
//
// ARB_MODE 0 selects round-robin with a rotating priority pointer,
// ARB_MODE 1 selects fixed priority with the lowest index winning.

module noc_vchannel_mux_credit #(
    parameter int FLIT_WIDTH = 32,
    parameter int CHANNELS   = 7,
    parameter int CREDITS    = 4,
    parameter int ARB_MODE   = 0
) (
    input  logic                                 clk,
    input  logic                                 rst,
    input  logic [CHANNELS-1:0][FLIT_WIDTH-1:0]  in_flit,
    input  logic [CHANNELS-1:0]                  in_last,
    input  logic [CHANNELS-1:0]                  in_valid,
    output logic [CHANNELS-1:0]                  in_ready,
    output logic [FLIT_WIDTH-1:0]                out_flit,
    output logic                                 out_last,
    output logic [CHANNELS-1:0]                  out_valid,
    input  logic [CHANNELS-1:0]                  credit_return,
    output logic                                 credit_err
);

    localparam int CW = $clog2(CREDITS + 1);
    localparam int IW = (CHANNELS > 1) ? $clog2(CHANNELS) : 1;

    localparam logic [CW-1:0] CRED_MAX = CW'(CREDITS);
    localparam logic [IW-1:0] IDX_LAST = IW'(CHANNELS - 1);
    localparam logic [IW:0]   CH_WRAP  = (IW + 1)'(CHANNELS);

    logic [CW-1:0]           credit [CHANNELS];
    logic [CHANNELS-1:0]     eligible;
    logic [CHANNELS-1:0]     grant;
    logic                    grant_any;
    logic [IW-1:0]           grant_idx;
    logic [IW-1:0]           rr_ptr;
    logic [IW-1:0]           rr_ptr_next;
    logic [2*CHANNELS-1:0]   elig_dbl;
    logic [2*CHANNELS-1:0]   elig_rot;
    logic [CHANNELS-1:0]     ret_at_max;
    logic [FLIT_WIDTH-1:0]   mux_flit;
    logic                    mux_last;

    // A VC may send only with a non-zero pre-update count, so a credit
    // returned this cycle becomes usable from the next cycle on. Nothing is
    // granted while reset is held.
    always_comb begin
        eligible   = '0;
        ret_at_max = '0;
        for (int c = 0; c < CHANNELS; c++) begin
            eligible[c]   = in_valid[c] & (credit[c] != '0) & ~rst;
            ret_at_max[c] = credit_return[c] & (credit[c] == CRED_MAX);
        end
    end

    // Round-robin search: rotate the doubled eligible vector so that bit 0
    // is the VC under the pointer, then take the lowest set bit. The loops
    // run high-to-low so that the last hit (lowest position) wins.
    always_comb begin
        logic [IW:0] sum;
        elig_dbl  = {eligible, eligible};
        elig_rot  = elig_dbl >> rr_ptr;
        grant_idx = '0;
        grant_any = 1'b0;
        sum       = '0;
        if (ARB_MODE == 1) begin
            for (int c = CHANNELS - 1; c >= 0; c--) begin
                if (eligible[c]) begin
                    grant_idx = IW'(c);
                    grant_any = 1'b1;
                end
            end
        end else begin
            for (int k = CHANNELS - 1; k >= 0; k--) begin
                if (elig_rot[k]) begin
                    sum = {1'b0, rr_ptr} + (IW + 1)'(k);
                    if (sum >= CH_WRAP) begin
                        sum = sum - CH_WRAP;
                    end
                    grant_idx = sum[IW-1:0];
                    grant_any = 1'b1;
                end
            end
        end
    end

    always_comb begin
        grant = '0;
        if (grant_any) begin
            grant = CHANNELS'(1) << grant_idx;
        end
    end

    assign in_ready = grant;

    // Grant is one-hot, so an AND-OR mux selects the winning flit.
    always_comb begin
        mux_flit = '0;
        mux_last = 1'b0;
        for (int c = 0; c < CHANNELS; c++) begin
            if (grant[c]) begin
                mux_flit = mux_flit | in_flit[c];
                mux_last = mux_last | in_last[c];
            end
        end
    end

    // Priority moves to the VC after the winner; it holds on idle cycles.
    always_comb begin
        rr_ptr_next = rr_ptr;
        if (grant_any) begin
            rr_ptr_next = (grant_idx == IDX_LAST) ? '0 : grant_idx + 1'b1;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            rr_ptr <= '0;
        end else begin
            rr_ptr <= rr_ptr_next;
        end
    end

    // Credit counters. A simultaneous send and return cancel out; a return
    // with no outstanding flit saturates at CREDITS.
    always_ff @(posedge clk) begin
        if (rst) begin
            for (int c = 0; c < CHANNELS; c++) begin
                credit[c] <= CRED_MAX;
            end
        end else begin
            for (int c = 0; c < CHANNELS; c++) begin
                case ({grant[c], credit_return[c]})
                    2'b10: credit[c] <= credit[c] - 1'b1;
                    2'b01: begin
                        if (credit[c] != CRED_MAX) begin
                            credit[c] <= credit[c] + 1'b1;
                        end
                    end
                    default: credit[c] <= credit[c];
                endcase
            end
        end
    end

    // A return against a full counter means the downstream side freed a slot
    // it never held; flag it even if a send happens in the same cycle.
    always_ff @(posedge clk) begin
        if (rst) begin
            credit_err <= 1'b0;
        end else if (|ret_at_max) begin
            credit_err <= 1'b1;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            out_valid <= '0;
            out_flit  <= '0;
            out_last  <= 1'b0;
        end else if (grant_any) begin
            out_valid <= grant;
            out_flit  <= mux_flit;
            out_last  <= mux_last;
        end else begin
            out_valid <= '0;
        end
    end

endmodule
